decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the core; parametrised successor of the combinational decoder.
- Decodes the full RV32 base opcode set for register-file size NUM_REGS: 16 gives RV32E, 32 gives RV32I.
- Adds a valid/ready handshake, a one-entry output register, a register scoreboard for RAW stalls, flush, and illegal-instruction detection.
- Sits between fetch (upstream) and execute (downstream).

Parameters:
- NUM_REGS, 16, architectural register count; legal values 16 or 32.
- REG_ADDR_W, $clog2(NUM_REGS), register index width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instruction  in  32  raw instruction word.
- in_pc  in  32  PC of the instruction.
- flush  in  1  discard the held and offered instruction.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  REG_ADDR_W  register being written back.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  32  registered PC.
- immediate  out  32  sign-extended immediate of the instruction's format.
- rd, rs1, rs2  out  REG_ADDR_W each  register indices; forced to 0 when the format has no such field.
- alu_operation  out  4  {bit30-qualifier, funct3}, encoded with the defines.vh ALU codes.
- alu_a_sel  out  1  `ALU_A_SEL_RS1 / `ALU_A_SEL_PC.
- alu_b_sel  out  1  `ALU_B_SEL_RS2 / `ALU_B_SEL_IMM.
- regfile_we  out  1  instruction writes rd.
- mem_read, mem_write  out  1 each  load / store.
- mem_funct3  out  3  access size and signedness (funct3).
- branch, jump  out  1 each  conditional branch / JAL or JALR.
- illegal  out  1  instruction is illegal.

Behaviour:
- Reset: out_valid=0, every other output 0, scoreboard cleared. in_ready is 0 during the reset cycle.
- Handshake: fire_in = in_valid & in_ready. fire_out = out_valid & out_ready.
  - in_ready = !rst & !flush & !stall & (!out_valid | out_ready).
  - On fire_in, decoded fields register the next cycle: latency 1. out_valid goes to 1.
  - On fire_out without fire_in, out_valid goes to 0.
  - The held bundle is stable while out_valid & !out_ready.
- Decode rules:
  - OP: alu_op = {funct7[5], funct3}, b_sel = RS2.
  - OP_IMM: alu_op = {funct3==101 ? funct7[5] : 0, funct3}, b_sel = IMM.
  - LUI: rs1 = 0, a_sel = RS1, imm_U, ADD.
  - AUIPC: a_sel = PC, imm_U, ADD.
  - JAL: jump=1, a_sel = PC, imm_J, we=1.
  - JALR: jump=1, imm_I, we=1.
  - BRANCH: branch=1, imm_B, b_sel = RS2, we=0, alu_op = {0, funct3}.
  - LOAD: mem_read=1, imm_I, ADD, we=1.
  - STORE: mem_write=1, imm_S, ADD, we=0.
  - FENCE: no-op, all enables 0, not illegal.
  - SYSTEM: flags illegal.
  - rd == 0 forces regfile_we = 0.
- Illegal conditions:
  - unknown opcode;
  - reserved funct3 for BRANCH, LOAD or STORE;
  - funct7 not 0000000 / 0100000 where the encoding requires it;
  - any used rd/rs1/rs2 field >= NUM_REGS.
- Illegal bundle: illegal=1, regfile_we, mem_read and mem_write forced to 0.
- Scoreboard: one busy bit per register; bit 0 always 0.
  - Set on fire_out when regfile_we=1.
  - Cleared on wb_valid for wb_rd.
  - Same register set and cleared in one cycle: set wins.
- Stall: the offered instruction reads a register (rs1 or rs2 used by its format) whose busy bit is 1, or writes an rd whose busy bit is 1 (WAW).
  - rd of the bundle currently in the output register also counts as busy if its regfile_we=1.
- Flush: the next cycle has out_valid=0. The offered instruction is not accepted. The scoreboard is unchanged, since held bundles never set bits. Flush beats fire_in and fire_out in the same cycle.
- wb_valid with wb_rd = 0 or an already clear bit: no effect.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: a wb_valid clear is applied combinationally before the stall check, so an instruction waiting on wb_rd is accepted in the same cycle as the writeback.
- Undefined: the stall check uses registered busy bits only; acceptance happens one cycle after wb_valid.

Test Plan:
- Reset, then in_valid with 0x00500093 (addi x1,x0,5) and out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, immediate=5, alu_op=0000, b_sel=IMM, regfile_we=1.
- srai x2,x1,3 (0x4030D113) -> alu_op=1101, immediate[4:0]=3. srli (0x0030D113) -> alu_op=0101.
- addi x1 fires out, then add x3,x1,x1 offered -> in_ready=0 until wb_valid with wb_rd=1.
  - Bypass undefined: accepted the cycle after wb.
  - Bypass defined: accepted in the same cycle as wb.
- NUM_REGS=16, add x17,x0,x0 (0x000008B3) -> illegal=1, regfile_we=0, scoreboard unchanged. NUM_REGS=32 with the same word -> legal, rd=17.
- out_ready=0 with a bundle held for 3 cycles -> outputs stable, in_ready=0. Flush asserted -> next cycle out_valid=0.
- Opcode 0x7F -> illegal=1. beq (funct3 000) -> branch=1, imm_B correct. Load with funct3=011 -> illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV32E decode with valid/ready, RAW/WAW scoreboard, flush.
// Optional DECODE_WB_BYPASS_EN lets a same-cycle writeback release a stall.
`ifndef ALU_A_SEL_RS1
`define ALU_A_SEL_RS1 1'b0
`define ALU_A_SEL_PC 1'b1
`define ALU_B_SEL_RS2 1'b0
`define ALU_B_SEL_IMM 1'b1
`define ALU_ADD 4'b0000
`endif

module decode_stage #(
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instruction,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           immediate,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [3:0]            alu_operation,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic                  regfile_we,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_funct3,
  output logic                  branch,
  output logic                  jump,
  output logic                  illegal
);

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic        f7_bad;

  assign ins    = in_instruction;
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign f_rd   = ins[11:7];
  assign f_rs1  = ins[19:15];
  assign f_rs2  = ins[24:20];
  assign f7_bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  logic is_op, is_opi, is_lui, is_auipc, is_jal;
  logic is_jalr, is_br, is_ld, is_st, is_fence;

  assign is_op    = opcode == 7'b0110011;
  assign is_opi   = opcode == 7'b0010011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_br    = opcode == 7'b1100011;
  assign is_ld    = opcode == 7'b0000011;
  assign is_st    = opcode == 7'b0100011;
  assign is_fence = opcode == 7'b0001111;

  logic [31:0] d_imm;
  logic [3:0]  d_alu;
  logic        d_a, d_b, d_we, d_mr, d_mw, d_br, d_jp, bad;
  logic        use_rd, use_rs1, use_rs2;

  // SYSTEM and unknown opcodes both land in default as illegal
  always_comb begin
    d_imm   = '0;
    d_alu   = `ALU_ADD;
    d_a     = `ALU_A_SEL_RS1;
    d_b     = `ALU_B_SEL_RS2;
    d_we    = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_br    = 1'b0;
    d_jp    = 1'b0;
    bad     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      is_op: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_alu   = {f7[5], f3};
        d_we    = 1'b1;
        bad     = f7_bad;
      end
      is_opi: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        d_imm   = imm_i;
        d_b     = `ALU_B_SEL_IMM;
        d_alu   = {(f3 == 3'b101) & f7[5], f3};
        d_we    = 1'b1;
        bad     = ((f3 == 3'b001) && (f7 != 7'b0))
               || ((f3 == 3'b101) && f7_bad);
      end
      is_lui: begin
        use_rd = 1'b1;
        d_imm  = imm_u;
        d_b    = `ALU_B_SEL_IMM;
        d_we   = 1'b1;
      end
      is_auipc: begin
        use_rd = 1'b1;
        d_imm  = imm_u;
        d_a    = `ALU_A_SEL_PC;
        d_b    = `ALU_B_SEL_IMM;
        d_we   = 1'b1;
      end
      is_jal: begin
        use_rd = 1'b1;
        d_imm  = imm_j;
        d_a    = `ALU_A_SEL_PC;
        d_b    = `ALU_B_SEL_IMM;
        d_we   = 1'b1;
        d_jp   = 1'b1;
      end
      is_jalr: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        d_imm   = imm_i;
        d_b     = `ALU_B_SEL_IMM;
        d_we    = 1'b1;
        d_jp    = 1'b1;
      end
      is_br: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_imm   = imm_b;
        d_alu   = {1'b0, f3};
        d_br    = 1'b1;
        bad     = f3[2:1] == 2'b01;
      end
      is_ld: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        d_imm   = imm_i;
        d_b     = `ALU_B_SEL_IMM;
        d_we    = 1'b1;
        d_mr    = 1'b1;
        bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      is_st: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_imm   = imm_s;
        d_b     = `ALU_B_SEL_IMM;
        d_mw    = 1'b1;
        bad     = f3[2] || (f3 == 3'b011);
      end
      is_fence: begin
      end
      default: bad = 1'b1;
    endcase
  end

  logic oob_rd, oob_rs1, oob_rs2, d_ill, we_fin;
  logic [REG_ADDR_W-1:0] i_rd, i_rs1, i_rs2;

  assign oob_rd  = use_rd  && ({1'b0, f_rd}  >= 6'(NUM_REGS));
  assign oob_rs1 = use_rs1 && ({1'b0, f_rs1} >= 6'(NUM_REGS));
  assign oob_rs2 = use_rs2 && ({1'b0, f_rs2} >= 6'(NUM_REGS));
  assign d_ill   = bad | oob_rd | oob_rs1 | oob_rs2;
  assign we_fin  = d_we & ~d_ill & (f_rd != 5'd0);

  assign i_rd  = use_rd  ? f_rd[REG_ADDR_W-1:0]  : '0;
  assign i_rs1 = use_rs1 ? f_rs1[REG_ADDR_W-1:0] : '0;
  assign i_rs2 = use_rs2 ? f_rs2[REG_ADDR_W-1:0] : '0;

  logic [NUM_REGS-1:0] busy, busy_n, hold_mask, wb_mask, eff;
  logic stall, fire_in, fire_out;

  always_comb begin
    hold_mask = '0;
    wb_mask   = '0;
    if (out_valid && regfile_we) hold_mask[rd] = 1'b1;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign eff = (busy & ~wb_mask) | hold_mask;
`else
  assign eff = busy | hold_mask;
`endif

  // out-of-range fields are illegal anyway; never let them alias a stall
  assign stall = (use_rs1 & ~oob_rs1 & eff[i_rs1])
               | (use_rs2 & ~oob_rs2 & eff[i_rs2])
               | (we_fin & eff[i_rd]);

  assign in_ready = ~rst & ~flush & ~stall & (~out_valid | out_ready);
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  always_comb begin
    busy_n = busy & ~wb_mask;
    if (fire_out && !flush) busy_n = busy_n | hold_mask;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      immediate     <= '0;
      rd            <= '0;
      rs1           <= '0;
      rs2           <= '0;
      alu_operation <= '0;
      alu_a_sel     <= 1'b0;
      alu_b_sel     <= 1'b0;
      regfile_we    <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_funct3    <= '0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      busy <= busy_n;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire_in) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        immediate     <= d_imm;
        rd            <= i_rd;
        rs1           <= i_rs1;
        rs2           <= i_rs2;
        alu_operation <= d_alu;
        alu_a_sel     <= d_a;
        alu_b_sel     <= d_b;
        regfile_we    <= we_fin;
        mem_read      <= d_mr & ~d_ill;
        mem_write     <= d_mw & ~d_ill;
        mem_funct3    <= (is_ld | is_st) ? f3 : 3'b000;
        branch        <= d_br;
        jump          <= d_jp;
        illegal       <= d_ill;
      end else if (fire_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors into a scoreboard queue; monitors pop on each output transfer.
// Expects DECODE_WB_BYPASS_EN to be defined identically for bench and design.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic        a;
    logic        b;
    logic        we;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic        br;
    logic        jp;
    logic        ill;
  } exp_t;

`ifdef DECODE_WB_BYPASS_EN
  localparam int BYP_WAIT = 0;
`else
  localparam int BYP_WAIT = 1;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
  logic [31:0] in_instruction, in_pc, out_pc, immediate;
  logic [3:0]  wb_rd, rd, rs1, rs2;
  logic [3:0]  alu_operation;
  logic        alu_a_sel, alu_b_sel, regfile_we, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic        branch, jump, illegal;

  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [31:0] w_in_instruction, w_in_pc, w_out_pc, w_immediate;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [3:0]  w_alu;
  logic        w_a, w_b, w_we, w_mr, w_mw, w_br, w_jp, w_ill;
  logic [2:0]  w_f3;

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t q32[$];

  decode_stage #(.NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .immediate(immediate),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .alu_operation(alu_operation),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .regfile_we(regfile_we), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  decode_stage #(.NUM_REGS(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_instruction(w_in_instruction), .in_pc(w_in_pc),
    .flush(1'b0), .wb_valid(1'b0), .wb_rd(5'd0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_pc(w_out_pc), .immediate(w_immediate),
    .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
    .alu_operation(w_alu),
    .alu_a_sel(w_a), .alu_b_sel(w_b),
    .regfile_we(w_we), .mem_read(w_mr),
    .mem_write(w_mw), .mem_funct3(w_f3),
    .branch(w_br), .jump(w_jp), .illegal(w_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [31:0] imm,
    input logic [4:0] r_d, input logic [4:0] r_s1,
    input logic [4:0] r_s2, input logic [3:0] alu,
    input logic a, input logic b, input logic we,
    input logic mr, input logic mw, input logic [2:0] f3,
    input logic br, input logic jp, input logic ill);
    exp_t e;
    e = '{pc: pc, imm: imm, rd: r_d, rs1: r_s1, rs2: r_s2,
          alu: alu, a: a, b: b, we: we, mr: mr, mw: mw,
          f3: f3, br: br, jp: jp, ill: ill};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t act, e;
    if (out_valid && out_ready) begin
      act = '{pc: out_pc, imm: immediate, rd: 5'(rd),
              rs1: 5'(rs1), rs2: 5'(rs2), alu: alu_operation,
              a: alu_a_sel, b: alu_b_sel, we: regfile_we,
              mr: mem_read, mw: mem_write, f3: mem_funct3,
              br: branch, jp: jump, ill: illegal};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL bundle16 unexpected got=%h", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL bundle16 pc=%h got=%h want=%h", e.pc, act, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t act, e;
    if (w_out_valid) begin
      act = '{pc: w_out_pc, imm: w_immediate, rd: w_rd,
              rs1: w_rs1, rs2: w_rs2, alu: w_alu,
              a: w_a, b: w_b, we: w_we, mr: w_mr, mw: w_mw,
              f3: w_f3, br: w_br, jp: w_jp, ill: w_ill};
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL bundle32 unexpected got=%h", act);
      end else begin
        e = q32.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL bundle32 pc=%h got=%h want=%h", e.pc, act, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e,
                      input bit push, output int w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_instruction = ins;
    in_pc = e.pc;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w >= 20) break;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout pc=%h got=stalled want=accept", e.pc);
    end else if (push) begin
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] r);
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_rd = r;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lo;
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instruction = '0;
    in_pc = '0;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_rd = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0;
    w_in_instruction = '0;
    w_in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out",
        {out_valid, regfile_we, illegal, rd, immediate[24:0]}, 32'd0);

    send(32'h00500093,
         mk(32'h100, 32'd5, 1, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, w);

    // add x3,x1,x1 waits on x1 until writeback
    e = mk(32'h104, 32'd0, 3, 1, 1, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    in_instruction = 32'h001081B3;
    in_pc = e.pc;
    lo = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready) lo++;
    end
    chk("raw_stall_ready_cycles", 32'(lo), 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_rd = 4'd1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      w++;
      if (w > 10) break;
    end
    chk("raw_release_delay", 32'(w), 32'(BYP_WAIT));
    if (in_ready) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb_valid = 1'b0;

    send(32'h4030D113,
         mk(32'h108, 32'h403, 2, 1, 0, 4'hD, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, w);
    wb(4'd2);
    send(32'h0030D113,
         mk(32'h10C, 32'h3, 2, 1, 0, 4'h5, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, w);
    send(32'h123452B7,
         mk(32'h110, 32'h12345000, 5, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0),
         1, w);
    send(32'hFFFFF317,
         mk(32'h114, 32'hFFFFF000, 6, 0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 0),
         1, w);
    send(32'h008003EF,
         mk(32'h118, 32'h8, 7, 0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1, w);
    send(32'hFE0008E3,
         mk(32'h11C, 32'hFFFFFFF0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
         1, w);
    send(32'h00003403,
         mk(32'h120, 32'h0, 8, 0, 0, 4'h0, 0, 1, 0, 0, 0, 3, 0, 0, 1), 1, w);
    send(32'h00402483,
         mk(32'h124, 32'h4, 9, 0, 0, 4'h0, 0, 1, 1, 1, 0, 2, 0, 0, 0), 1, w);
    send(32'h00402623,
         mk(32'h128, 32'd12, 0, 0, 4, 4'h0, 0, 1, 0, 0, 1, 2, 0, 0, 0), 1, w);
    send(32'h0000007F,
         mk(32'h12C, 32'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, w);
    send(32'h000008B3,
         mk(32'h130, 32'h0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, w);
    send(32'h00008533,
         mk(32'h134, 32'h0, 10, 1, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, w);
    chk("illegal_x17_no_busy_wait", 32'(w), 32'd0);
    send(32'h0000000F,
         mk(32'h138, 32'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, w);
    send(32'h00000073,
         mk(32'h13C, 32'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, w);

    idle(3);
    out_ready = 1'b0;
    send(32'hFFF00593,
         mk(32'h140, 32'hFFFFFFFF, 11, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0),
         0, w);
    in_valid = 1'b1;
    in_instruction = 32'h00000613;
    in_pc = 32'h144;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_stable",
          {in_ready, out_valid, regfile_we, rd, immediate[24:0]},
          {1'b0, 1'b1, 1'b1, 4'd11, 25'h1FFFFFF});
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush_offer_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(32'h000586B3,
         mk(32'h148, 32'h0, 13, 11, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, w);
    chk("flush_no_busy_wait", 32'(w), 32'd0);

    @(posedge clk); #1;
    w_in_valid = 1'b1;
    w_in_instruction = 32'h000008B3;
    w_in_pc = 32'h200;
    @(negedge clk);
    chk("rv32i_in_ready", 32'(w_in_ready), 32'd1);
    if (w_in_ready)
      q32.push_back(mk(32'h200, 32'h0, 17, 0, 0, 4'h0,
                       0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    w_in_valid = 1'b0;

    idle(5);
    chk("queues_drained", 32'(q.size() + q32.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
